clk_div_bank: RTL

//  Parametrised bank of NUM_CH clock-divider channels. It generalises the fixed divide-by-2 stages

---
 rtl/clk_div_bank.sv | 99 +++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable clock dividers with enable, tick and
// deferred (period-boundary) divisor updates.
module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  localparam int NSEL = 2 ** CH_W;

  logic [CNT_W-1:0]  wr_div;
  logic [NSEL-1:0]   pend_ext;
  logic [NUM_CH-1:0] pend;

  assign wr_div = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

  // Unused selector codes read as not-pending, so they always look ready.
  always_comb begin
    pend_ext = '0;
    pend_ext[NUM_CH-1:0] = pend;
  end

  assign cfg_ready = ~pend_ext[cfg_ch];
  assign busy      = pend;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             en_q;
    logic             dclk_q;
    logic             pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] nxt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             wrap;
    logic             wr;

    assign wrap    = (cnt_q == cur_q - CNT_W'(1));
    assign wr      = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
    assign cnt_inc = wrap ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        en_q   <= 1'b0;
        dclk_q <= 1'b0;
        pend_q <= 1'b0;
        cnt_q  <= '0;
        cur_q  <= CNT_W'(DEFAULT_DIV);
        nxt_q  <= CNT_W'(DEFAULT_DIV);
      end else if (!en_q) begin
        cnt_q <= '0;
        if (wr) cur_q <= wr_div;
        if (ch_en[i]) begin
          en_q   <= 1'b1;
          dclk_q <= 1'b1;
        end
      end else if (!ch_en[i]) begin
        en_q   <= 1'b0;
        cnt_q  <= '0;
        dclk_q <= 1'b0;
        // A stopped channel has no boundary to wait for.
        if (pend_q) begin
          cur_q  <= nxt_q;
          pend_q <= 1'b0;
        end else if (wr) begin
          cur_q <= wr_div;
        end
      end else if (pend_q && wrap) begin
        cur_q  <= nxt_q;
        pend_q <= 1'b0;
        cnt_q  <= '0;
        dclk_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_inc;
        dclk_q <= (cnt_inc < (cur_q >> 1));
        if (wr) begin
          nxt_q  <= wr_div;
          pend_q <= 1'b1;
        end
      end
    end

    assign tick[i]    = en_q & wrap;
    assign div_clk[i] = dclk_q;
    assign pend[i]    = pend_q;
  end

endmodule
